gpu_pixel_arbiter: RTL

//  Shares the single framebuffer pixel-write port between the three rasterizer engines:

---
 rtl/gpu_pixel_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/gpu_pixel_arbiter.sv
// Round-robin arbiter sharing the framebuffer pixel-write port between the
// line, fill and arc rasterizer engines, with a saturating written-pixel count.
module gpu_pixel_arbiter #(
  parameter int X_BITS   = 10,
  parameter int Y_BITS   = 9,
  parameter int CNT_BITS = 16
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic [2:0]            req_i,
  input  logic [3*X_BITS-1:0]   x_i,
  input  logic [3*Y_BITS-1:0]   y_i,
  input  logic                  clr_cnt_i,
  input  logic                  mem_ready_i,
  output logic [2:0]            ack_o,
  output logic                  mem_wr_o,
  output logic [X_BITS-1:0]     mem_x_o,
  output logic [Y_BITS-1:0]     mem_y_o,
  output logic [1:0]            grant_o,
  output logic                  busy_o,
  output logic [CNT_BITS-1:0]   pix_cnt_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [1:0]          NO_GRANT = 2'd3;
  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

  state_t              state, state_nxt;
  logic [1:0]          rr_ptr, rr_ptr_nxt;
  logic [1:0]          grant_nxt;
  logic                mem_wr_nxt;
  logic [X_BITS-1:0]   x_nxt, win_x;
  logic [Y_BITS-1:0]   y_nxt, win_y;
  logic [2:0]          grant_mask, elig;
  logic [1:0]          search_base, cand0, cand1, cand2;
  logic                win_valid;
  logic [1:0]          win_idx;
  logic                done;

  function automatic logic [1:0] next_idx(input logic [1:0] v);
    next_idx = (v >= 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  function automatic logic bit_of(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    bit_of = v[0];
      2'd1:    bit_of = v[1];
      2'd2:    bit_of = v[2];
      default: bit_of = 1'b0;
    endcase
  endfunction

  // The engine currently being written still holds its request, so it is
  // masked out; during WRITE the search starts just past it.
  always_comb begin
    case (grant_o)
      2'd0:    grant_mask = 3'b001;
      2'd1:    grant_mask = 3'b010;
      2'd2:    grant_mask = 3'b100;
      default: grant_mask = 3'b000;
    endcase
    elig        = req_i & ~grant_mask;
    search_base = (state == WRITE) ? next_idx(grant_o) : rr_ptr;
    cand0       = search_base;
    cand1       = next_idx(cand0);
    cand2       = next_idx(cand1);
  end

  always_comb begin
    win_valid = 1'b1;
    win_idx   = cand0;
    if (bit_of(elig, cand0))      win_idx = cand0;
    else if (bit_of(elig, cand1)) win_idx = cand1;
    else if (bit_of(elig, cand2)) win_idx = cand2;
    else                          win_valid = 1'b0;
  end

  always_comb begin
    case (win_idx)
      2'd0: begin
        win_x = x_i[0 +: X_BITS];
        win_y = y_i[0 +: Y_BITS];
      end
      2'd1: begin
        win_x = x_i[X_BITS +: X_BITS];
        win_y = y_i[Y_BITS +: Y_BITS];
      end
      default: begin
        win_x = x_i[2*X_BITS +: X_BITS];
        win_y = y_i[2*Y_BITS +: Y_BITS];
      end
    endcase
  end

  assign done   = (state == WRITE) && mem_ready_i;
  assign ack_o  = done ? grant_mask : 3'b000;
  assign busy_o = (state == WRITE);

  // A completed write reloads straight from the next winner so a stream of
  // requests sees no idle cycle between pixels.
  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    grant_nxt  = grant_o;
    mem_wr_nxt = mem_wr_o;
    x_nxt      = mem_x_o;
    y_nxt      = mem_y_o;
    case (state)
      IDLE: begin
        if (win_valid) begin
          state_nxt  = WRITE;
          grant_nxt  = win_idx;
          mem_wr_nxt = 1'b1;
          x_nxt      = win_x;
          y_nxt      = win_y;
        end
      end
      WRITE: begin
        if (mem_ready_i) begin
          rr_ptr_nxt = next_idx(grant_o);
          if (win_valid) begin
            grant_nxt  = win_idx;
            mem_wr_nxt = 1'b1;
            x_nxt      = win_x;
            y_nxt      = win_y;
          end else begin
            state_nxt  = IDLE;
            grant_nxt  = NO_GRANT;
            mem_wr_nxt = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      rr_ptr   <= 2'd0;
      grant_o  <= NO_GRANT;
      mem_wr_o <= 1'b0;
      mem_x_o  <= '0;
      mem_y_o  <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_ptr_nxt;
      grant_o  <= grant_nxt;
      mem_wr_o <= mem_wr_nxt;
      mem_x_o  <= x_nxt;
      mem_y_o  <= y_nxt;
    end
  end

  // Clear wins over a simultaneous completed write; the count never wraps.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_cnt_o <= '0;
    end else if (clr_cnt_i) begin
      pix_cnt_o <= '0;
    end else if (done && (pix_cnt_o != CNT_MAX)) begin
      pix_cnt_o <= pix_cnt_o + CNT_BITS'(1);
    end
  end

endmodule
